timer_controller: RTL and testbench

Sequencing controller for the BCD mm:ss countdown timer.
- Conditions the four user buttons.
- Owns the 16-bit time register and issues single-cycle add/sub strobes to the existing minute-adjust datapath.
- Runs the 1 Hz BCD countdown and flags expiry.
- Sits between the button inputs and the minute-adjust datapath / display.

---
 rtl/timer_pkg.sv | 35 +++
 rtl/timer_bcd_dec.sv | 40 ++++
 rtl/timer_controller.sv | 168 ++++++++++++++++
 tb/tb_timer_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD mm:ss countdown timer controller.
// The time word packs four BCD digits, from mm_tens down to ss_ones.
package timer_pkg;

  typedef enum logic [1:0] {
    StSet   = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } timer_state_e;

  typedef struct packed {
    logic [3:0] mm_tens;
    logic [3:0] mm_ones;
    logic [3:0] ss_tens;
    logic [3:0] ss_ones;
  } bcd_time_t;

  localparam int unsigned SsOnesLsb = 0;
  localparam int unsigned SsTensLsb = 4;
  localparam int unsigned MmOnesLsb = 8;
  localparam int unsigned MmTensLsb = 12;

  localparam logic [3:0] DigitMax9 = 4'd9;
  localparam logic [3:0] DigitMax5 = 4'd5;

  localparam logic [15:0] ZERO_TIME = 16'h0000;

  localparam int unsigned BtnAdd   = 0;
  localparam int unsigned BtnSub   = 1;
  localparam int unsigned BtnStart = 2;
  localparam int unsigned BtnClear = 3;
  localparam int unsigned NumBtns  = 4;

endpackage

// File: rtl/timer_bcd_dec.sv
// Combinational one-second decrement of a BCD mm:ss time word.
// An input of 00:00 is returned unchanged rather than wrapping.
module timer_bcd_dec
  import timer_pkg::*;
(
  input  logic [15:0] time_i,
  output logic [15:0] time_o,
  output logic        is_zero_o
);

  bcd_time_t cur;
  bcd_time_t nxt;

  always_comb begin
    cur = time_i;
    nxt = cur;
    if (time_i != ZERO_TIME) begin
      if (cur.ss_ones != 4'd0) begin
        nxt.ss_ones = cur.ss_ones - 4'd1;
      end else begin
        nxt.ss_ones = DigitMax9;
        if (cur.ss_tens != 4'd0) begin
          nxt.ss_tens = cur.ss_tens - 4'd1;
        end else begin
          nxt.ss_tens = DigitMax5;
          if (cur.mm_ones != 4'd0) begin
            nxt.mm_ones = cur.mm_ones - 4'd1;
          end else begin
            nxt.mm_ones = DigitMax9;
            nxt.mm_tens = cur.mm_tens - 4'd1;
          end
        end
      end
    end
  end

  assign time_o    = nxt;
  assign is_zero_o = (nxt == ZERO_TIME);

endmodule

// File: rtl/timer_controller.sv
// Sequencing controller for the BCD mm:ss countdown timer: button conditioning,
// minute-adjust strobes, 1 Hz countdown and expiry detection.
module timer_controller
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_add,
  input  logic        btn_sub,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic [15:0] adj_result,
  output logic [15:0] adj_time,
  output logic        adj_add,
  output logic        adj_sub,
  output logic [1:0]  state,
  output logic        running,
  output logic        expired
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

  // Button conditioning: synchroniser chain then rising-edge detect.
  logic [NumBtns-1:0] btn_raw;
  logic [SYNC_STAGES-1:0][NumBtns-1:0] sync_q, sync_d;
  logic [NumBtns-1:0] btn_sync;
  logic [NumBtns-1:0] edge_q, edge_d;
  logic [NumBtns-1:0] btn_evt;

  assign btn_raw[BtnAdd]   = btn_add;
  assign btn_raw[BtnSub]   = btn_sub;
  assign btn_raw[BtnStart] = btn_start;
  assign btn_raw[BtnClear] = btn_clear;

  always_comb begin
    sync_d[0] = btn_raw;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign btn_sync = sync_q[SYNC_STAGES-1];
  assign edge_d   = btn_sync;
  assign btn_evt  = btn_sync & ~edge_q;

  logic evt_add, evt_sub, evt_start, evt_clear;
  assign evt_add   = btn_evt[BtnAdd];
  assign evt_sub   = btn_evt[BtnSub];
  assign evt_start = btn_evt[BtnStart];
  assign evt_clear = btn_evt[BtnClear];

  // Sequencing state.
  timer_state_e     state_q, state_d;
  logic [15:0]      time_q, time_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic             add_q, add_d;
  logic             sub_q, sub_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;
  logic             strobe_busy;

  logic [15:0] dec_time;
  logic        dec_zero;

  timer_bcd_dec u_bcd_dec (
    .time_i    (time_q),
    .time_o    (dec_time),
    .is_zero_o (dec_zero)
  );

  assign strobe_busy = add_q | sub_q;

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    tick_d  = tick_q;
    add_d   = 1'b0;
    sub_d   = 1'b0;

    // The datapath result is captured on the edge that closes a strobe.
    if (strobe_busy) begin
      time_d = adj_result;
    end

    if (evt_clear) begin
      state_d = StSet;
      time_d  = ZERO_TIME;
      tick_d  = '0;
    end else begin
      unique case (state_q)
        StSet: begin
          if (evt_start) begin
            if (time_q != ZERO_TIME) begin
              state_d = StRun;
              tick_d  = '0;
            end
          end else if (!strobe_busy && (evt_add ^ evt_sub)) begin
            add_d = evt_add;
            sub_d = evt_sub;
          end
        end
        StRun: begin
          if (evt_start) begin
            state_d = StPause;
          end else if (tick_q == TickLast) begin
            tick_d = '0;
            time_d = dec_time;
            if (dec_zero) begin
              state_d = StDone;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        StPause: begin
          if (evt_start) begin
            state_d = StRun;
          end
        end
        StDone: begin
          time_d = ZERO_TIME;
        end
        default: begin
          state_d = StSet;
        end
      endcase
    end

    running_d = (state_d == StRun);
    expired_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      edge_q    <= '0;
      state_q   <= StSet;
      time_q    <= ZERO_TIME;
      tick_q    <= '0;
      add_q     <= 1'b0;
      sub_q     <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      edge_q    <= edge_d;
      state_q   <= state_d;
      time_q    <= time_d;
      tick_q    <= tick_d;
      add_q     <= add_d;
      sub_q     <= sub_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  assign adj_time = time_q;
  assign adj_add  = add_q;
  assign adj_sub  = sub_q;
  assign state    = state_q;
  assign running  = running_q;
  assign expired  = expired_q;

endmodule

// File: tb/tb_timer_controller.sv
// Directed bench for timer_controller with TICK_DIV=4 and two-stage synchronisers.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_timer_controller;

  localparam int unsigned TickDiv = 4;
  localparam int BAdd   = 0;
  localparam int BSub   = 1;
  localparam int BStart = 2;
  localparam int BClr   = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  btn;
  logic [15:0] dp_result;
  logic [15:0] adj_time;
  logic        adj_add;
  logic        adj_sub;
  logic [1:0]  state;
  logic        running;
  logic        expired;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  timer_controller #(
    .TICK_DIV    (TickDiv),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_add    (btn[BAdd]),
    .btn_sub    (btn[BSub]),
    .btn_start  (btn[BStart]),
    .btn_clear  (btn[BClr]),
    .adj_result (dp_result),
    .adj_time   (adj_time),
    .adj_add    (adj_add),
    .adj_sub    (adj_sub),
    .state      (state),
    .running    (running),
    .expired    (expired)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle press; returns on the falling edge where the button drops.
  task automatic press(input int idx);
    @(negedge clk);
    btn[idx] = 1'b1;
    @(negedge clk);
    btn[idx] = 1'b0;
  endtask

  task automatic load_time(input logic [15:0] val);
    dp_result = val;
    press(BAdd);
    cyc(4);
    check("load_time", adj_time, val);
  endtask

  task automatic clear_to_set();
    press(BClr);
    cyc(2);
    check("clear_state", 16'(state), 16'h0000);
    check("clear_time", adj_time, 16'h0000);
  endtask

  task automatic start_run();
    press(BStart);
    cyc(2);
    check("start_state", 16'(state), 16'h0001);
    check("start_running", 16'(running), 16'h0001);
  endtask

  int          n_add;
  int          n_sub;
  int          add_at;
  logic [15:0] t3;
  logic [15:0] t4;

  initial begin
    reset     = 1'b1;
    btn       = '0;
    dp_result = 16'h0000;
    #12;
    check("rst_state", 16'(state), 16'h0000);
    check("rst_time", adj_time, 16'h0000);
    check("rst_add", 16'(adj_add), 16'h0000);
    check("rst_sub", 16'(adj_sub), 16'h0000);
    check("rst_running", 16'(running), 16'h0000);
    check("rst_expired", 16'(expired), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    cyc(2);

    // Held add button: one strobe, time updated one cycle after it.
    dp_result = 16'h0100;
    n_add = 0; n_sub = 0; add_at = 0; t3 = '0; t4 = '0;
    @(negedge clk);
    btn[BAdd] = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 10) btn[BAdd] = 1'b0;
      if (adj_add) begin
        n_add++;
        add_at = c;
      end
      if (adj_sub) n_sub++;
      if (c == 3) t3 = adj_time;
      if (c == 4) t4 = adj_time;
    end
    check("hold_add_pulses", 16'(n_add), 16'd1);
    check("hold_add_cycle", 16'(add_at), 16'd3);
    check("hold_sub_pulses", 16'(n_sub), 16'd0);
    check("hold_time_before", t3, 16'h0000);
    check("hold_time_after", t4, 16'h0100);

    // Countdown 0100 -> 0059 -> 0058.
    start_run();
    cyc(3);
    check("run_no_dec_yet", adj_time, 16'h0100);
    cyc(1);
    check("run_dec_0059", adj_time, 16'h0059);
    cyc(4);
    check("run_dec_0058", adj_time, 16'h0058);
    clear_to_set();

    // Full borrow chain 1000 -> 0959.
    load_time(16'h1000);
    start_run();
    cyc(4);
    check("borrow_0959", adj_time, 16'h0959);
    clear_to_set();

    // Expiry 0002 -> 0001 -> 0000 / DONE.
    load_time(16'h0002);
    start_run();
    cyc(4);
    check("exp_0001", adj_time, 16'h0001);
    cyc(3);
    check("exp_still_run", 16'(state), 16'h0001);
    cyc(1);
    check("exp_time", adj_time, 16'h0000);
    check("exp_state", 16'(state), 16'h0003);
    check("exp_expired", 16'(expired), 16'h0001);
    check("exp_running", 16'(running), 16'h0000);
    press(BStart);
    cyc(4);
    check("done_start_ign", 16'(state), 16'h0003);
    dp_result = 16'h0100;
    press(BAdd);
    cyc(4);
    check("done_add_ign", adj_time, 16'h0000);
    clear_to_set();
    check("clear_expired", 16'(expired), 16'h0000);

    // Pause at tick count 2, hold, resume: decrement two cycles after resume.
    load_time(16'h0100);
    @(negedge clk);
    btn[BStart] = 1'b1;
    @(negedge clk);
    btn[BStart] = 1'b0;
    cyc(2);
    check("pz_run", 16'(state), 16'h0001);
    btn[BStart] = 1'b1;
    @(negedge clk);
    btn[BStart] = 1'b0;
    cyc(6);
    check("pz_state", 16'(state), 16'h0002);
    check("pz_time_frozen", adj_time, 16'h0100);
    cyc(13);
    btn[BStart] = 1'b1;
    @(negedge clk);
    btn[BStart] = 1'b0;
    @(negedge clk);
    check("pz_still_paused", 16'(state), 16'h0002);
    @(negedge clk);
    check("pz_resumed", 16'(state), 16'h0001);
    @(negedge clk);
    check("pz_no_dec", adj_time, 16'h0100);
    @(negedge clk);
    check("pz_dec", adj_time, 16'h0059);

    // Clear+start together in PAUSE: clear wins.
    press(BStart);
    cyc(2);
    check("cs_paused", 16'(state), 16'h0002);
    @(negedge clk);
    btn[BClr] = 1'b1;
    btn[BStart] = 1'b1;
    @(negedge clk);
    btn = '0;
    cyc(2);
    check("cs_state", 16'(state), 16'h0000);
    check("cs_time", adj_time, 16'h0000);

    // Add+sub together in SET: both dropped.
    load_time(16'h0100);
    dp_result = 16'h0200;
    n_add = 0; n_sub = 0;
    @(negedge clk);
    btn[BAdd] = 1'b1;
    btn[BSub] = 1'b1;
    @(negedge clk);
    btn = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (adj_add) n_add++;
      if (adj_sub) n_sub++;
    end
    check("as_add", 16'(n_add), 16'd0);
    check("as_sub", 16'(n_sub), 16'd0);
    check("as_time", adj_time, 16'h0100);

    // Asynchronous reset in the middle of a RUN at 0130.
    clear_to_set();
    load_time(16'h0130);
    start_run();
    cyc(2);
    #2;
    reset = 1'b1;
    #1;
    check("ar_state", 16'(state), 16'h0000);
    check("ar_time", adj_time, 16'h0000);
    check("ar_running", 16'(running), 16'h0000);
    check("ar_add", 16'(adj_add), 16'h0000);
    check("ar_sub", 16'(adj_sub), 16'h0000);
    check("ar_expired", 16'(expired), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    cyc(6);
    check("ar_hold_state", 16'(state), 16'h0000);
    check("ar_hold_time", adj_time, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
